gg_pcm_ctrl: RTL and testbench

Per-macroblock PCM decision and sequencing controller placed between the PCM buffer output stream and the bitstream packer. For each MB it consumes one decision token carrying the coded MB size. It either forwards the MB's 24 raster PCM words downstream (I_PCM) or drains and discards them (coded MB). It emits a header token so the mb_type writer knows which path was taken.

---
 rtl/gg_pcm_pkg.sv | 25 ++
 rtl/gg_pcm_ctrl_if.sv | 30 +++
 rtl/gg_sat_cnt.sv | 31 +++
 rtl/gg_pcm_ctrl.sv | 118 +++++++++++
 tb/tb_gg_pcm_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gg_pcm_pkg.sv
// Shared types and constants for the PCM decision/sequencing controller.
package gg_pcm_pkg;

  localparam int MB_WORDS = 24;
  localparam int BITS_W   = 16;
  localparam int DATA_W   = 128;
  localparam int CNT_W    = 5;

  // 256 luma + 128 chroma samples at 8 bits, plus mb_type/alignment overhead.
  localparam int PCM_HDR_BITS = 16;
  localparam logic [BITS_W-1:0] PCM_THRESH_NOM = BITS_W'(3072 + PCM_HDR_BITS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PCM   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  function automatic logic pcm_decide(input logic              force_pcm,
                                      input logic [BITS_W-1:0] bits,
                                      input logic [BITS_W-1:0] thresh);
    return force_pcm | (bits >= thresh);
  endfunction

endpackage

// File: rtl/gg_pcm_ctrl_if.sv
// Decision, header, PCM-in and PCM-out streams of the PCM controller.
interface gg_pcm_ctrl_if;
  import gg_pcm_pkg::*;

  logic [BITS_W-1:0] d_bits;
  logic              d_valid;
  logic              d_ready;
  logic              h_pcm;
  logic              h_valid;
  logic              h_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output d_bits, d_valid, h_ready, s_data, s_last, s_valid, m_ready,
    input  d_ready, h_pcm, h_valid, s_ready, m_data, m_last, m_valid
  );

  modport slave (
    input  d_bits, d_valid, h_ready, s_data, s_last, s_valid, m_ready,
    output d_ready, h_pcm, h_valid, s_ready, m_data, m_last, m_valid
  );

endinterface

// File: rtl/gg_sat_cnt.sv
// Saturating up-counter with asynchronous active-high reset.
module gg_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/gg_pcm_ctrl.sv
// Per-MB PCM decision: forwards or drains each MB's PCM words and emits a header token.
// Define GG_PCM_STATS_EN to enable the saturating PCM/total MB counters.
module gg_pcm_ctrl
  import gg_pcm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [BITS_W-1:0] cfg_pcm_thresh,
  input  logic              cfg_force_pcm,
  gg_pcm_ctrl_if.slave      io,
  output logic              err_len,
  output logic [15:0]       stat_pcm_mbs,
  output logic [15:0]       stat_tot_mbs
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             pcm_sel;
  logic             fire;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_max;
  logic             end_cond;
  logic             mb_end;

  assign pcm_sel  = pcm_decide(cfg_force_pcm, io.d_bits, cfg_pcm_thresh);
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign at_max   = (cnt_inc == CNT_W'(MB_WORDS));
  assign end_cond = io.s_last | at_max;
  assign mb_end   = fire & end_cond;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    fire       = 1'b0;
    io.d_ready = 1'b0;
    io.h_valid = 1'b0;
    io.h_pcm   = 1'b0;
    io.s_ready = 1'b0;
    io.m_data  = '0;
    io.m_valid = 1'b0;
    io.m_last  = 1'b0;

    case (state_q)
      S_IDLE: begin
        io.h_valid = io.d_valid;
        io.h_pcm   = pcm_sel;
        io.d_ready = io.h_ready;
        if (io.d_valid && io.h_ready) begin
          state_d = pcm_sel ? S_PCM : S_DRAIN;
        end
      end
      S_PCM: begin
        io.m_data  = io.s_data;
        io.m_valid = io.s_valid;
        io.s_ready = io.m_ready;
        io.m_last  = io.s_valid & end_cond;
        fire       = io.s_valid & io.m_ready;
      end
      S_DRAIN: begin
        io.s_ready = 1'b1;
        fire       = io.s_valid;
      end
      default: state_d = S_IDLE;
    endcase

    if (fire) begin
      cnt_d = cnt_inc;
    end
    // An early s_last and a missing s_last at the 24th beat both flag a length error.
    if (mb_end) begin
      cnt_d   = '0;
      state_d = S_IDLE;
      if (io.s_last ^ at_max) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign err_len = err_q;

`ifdef GG_PCM_STATS_EN
  logic pcm_end;
  assign pcm_end = mb_end & (state_q == S_PCM);

  gg_sat_cnt #(.W(16)) u_cnt_pcm (
    .clk   (clk),
    .reset (reset),
    .inc   (pcm_end),
    .cnt   (stat_pcm_mbs)
  );

  gg_sat_cnt #(.W(16)) u_cnt_tot (
    .clk   (clk),
    .reset (reset),
    .inc   (mb_end),
    .cnt   (stat_tot_mbs)
  );
`else
  assign stat_pcm_mbs = 16'd0;
  assign stat_tot_mbs = 16'd0;
`endif

endmodule

// File: tb/tb_gg_pcm_ctrl.sv
// Directed self-checking bench for gg_pcm_ctrl (forward, drain, stalls, length errors, reset, stats).
module tb_gg_pcm_ctrl;
  import gg_pcm_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [BITS_W-1:0] cfg_pcm_thresh;
  logic              cfg_force_pcm;
  logic              err_len;
  logic [15:0]       stat_pcm_mbs;
  logic [15:0]       stat_tot_mbs;

  int n_assert = 0;
  int n_fail   = 0;

  gg_pcm_ctrl_if bus ();

  gg_pcm_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_pcm_thresh (cfg_pcm_thresh),
    .cfg_force_pcm  (cfg_force_pcm),
    .io             (bus),
    .err_len        (err_len),
    .stat_pcm_mbs   (stat_pcm_mbs),
    .stat_tot_mbs   (stat_tot_mbs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] word(input int mb, input int b);
    return {32'(mb), 32'(b), 32'hC0DE0000 | 32'(b), 32'(mb * 100 + b)};
  endfunction

  // Probe the idle state without transferring anything; returns inputs to quiet.
  task automatic idle_check(input string tag);
    bus.d_valid = 1'b1;
    bus.h_ready = 1'b0;
    bus.s_valid = 1'b1;
    #1;
    chk({tag, " idle h_valid"}, bus.h_valid, 1'b1);
    chk({tag, " idle d_ready"}, bus.d_ready, 1'b0);
    chk({tag, " idle s_ready"}, bus.s_ready, 1'b0);
    chk({tag, " idle m_valid"}, bus.m_valid, 1'b0);
    bus.d_valid = 1'b0;
    bus.s_valid = 1'b0;
    #1;
  endtask

  task automatic decide(input string tag, input logic [15:0] bits, input logic exp_pcm);
    bus.d_bits  = bits;
    bus.d_valid = 1'b1;
    bus.h_ready = 1'b1;
    #1;
    chk({tag, " h_valid"}, bus.h_valid, 1'b1);
    chk({tag, " h_pcm"},   bus.h_pcm,   exp_pcm);
    chk({tag, " d_ready"}, bus.d_ready, 1'b1);
    step();
    bus.d_valid = 1'b0;
    bus.h_ready = 1'b0;
  endtask

  task automatic pcm_mb(input string tag, input int mb, input int n, input int last_at,
                        input bit toggle);
    int  b   = 1;
    int  cyc = 0;
    bit  mr;
    while (b <= n && cyc < 200) begin
      mr = toggle ? ((cyc % 2) == 0) : 1'b1;
      bus.m_ready = mr;
      bus.s_valid = 1'b1;
      bus.s_data  = word(mb, b);
      bus.s_last  = (b == last_at);
      #1;
      chk({tag, " m_valid"}, bus.m_valid, 1'b1);
      chk({tag, " m_data"},  bus.m_data,  word(mb, b));
      chk({tag, " m_last"},  bus.m_last,  (b == last_at) || (b == MB_WORDS));
      chk({tag, " s_ready"}, bus.s_ready, mr);
      step();
      cyc++;
      if (mr) b++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    chk({tag, " cycles"}, 128'(cyc), toggle ? 128'(2 * n - 1) : 128'(n));
  endtask

  task automatic drain_mb(input string tag, input int mb, input int n, input int last_at);
    for (int b = 1; b <= n; b++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = word(mb, b);
      bus.s_last  = (b == last_at);
      #1;
      chk({tag, " s_ready"}, bus.s_ready, 1'b1);
      chk({tag, " m_valid"}, bus.m_valid, 1'b0);
      step();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    cfg_pcm_thresh = 16'd3200;
    cfg_force_pcm  = 1'b0;
    bus.d_bits     = '0;
    bus.d_valid    = 1'b0;
    bus.h_ready    = 1'b0;
    bus.s_data     = '0;
    bus.s_last     = 1'b0;
    bus.s_valid    = 1'b0;
    bus.m_ready    = 1'b1;
    #1;
    chk("rst h_valid", bus.h_valid, 1'b0);
    chk("rst s_ready", bus.s_ready, 1'b0);
    chk("rst m_valid", bus.m_valid, 1'b0);
    chk("rst err_len", err_len, 1'b0);
    chk("rst stat_pcm", stat_pcm_mbs, 16'd0);
    chk("rst stat_tot", stat_tot_mbs, 16'd0);
    step();
    step();
    reset = 1'b0;
    step();
    $display("txn: reset released");

    // 1: PCM MB forwarded unchanged
    decide("t1 dec", 16'd4000, 1'b1);
    pcm_mb("t1", 1, 24, 24, 1'b0);
    idle_check("t1");
    chk("t1 err_len", err_len, 1'b0);
    $display("txn: t1 PCM MB 24 beats");

    // 2: coded MB drained
    decide("t2 dec", 16'd1000, 1'b0);
    drain_mb("t2", 2, 24, 24);
    idle_check("t2");
    chk("t2 err_len", err_len, 1'b0);
    $display("txn: t2 coded MB drained");

    // 3: PCM with m_ready toggling
    decide("t3 dec", 16'd5000, 1'b1);
    pcm_mb("t3", 3, 24, 24, 1'b1);
    idle_check("t3");
    $display("txn: t3 PCM MB with backpressure");

    // 4: early last, then missing last
    decide("t4a dec", 16'd3500, 1'b1);
    pcm_mb("t4a", 4, 20, 20, 1'b0);
    idle_check("t4a");
    chk("t4a err_len", err_len, 1'b1);
    decide("t4b dec", 16'd1000, 1'b0);
    drain_mb("t4b", 5, 24, 0);
    idle_check("t4b");
    chk("t4b err_len", err_len, 1'b1);
    $display("txn: t4 length errors");

    // 5: force PCM with header stall, then equality boundary
    cfg_force_pcm = 1'b1;
    bus.d_bits    = 16'd0;
    bus.d_valid   = 1'b1;
    bus.h_ready   = 1'b0;
    #1;
    chk("t5 h_pcm force", bus.h_pcm, 1'b1);
    chk("t5 d_ready stall", bus.d_ready, 1'b0);
    step();
    chk("t5 still idle h_valid", bus.h_valid, 1'b1);
    chk("t5 still idle s_ready", bus.s_ready, 1'b0);
    bus.h_ready = 1'b1;
    #1;
    chk("t5 d_ready go", bus.d_ready, 1'b1);
    step();
    bus.d_valid = 1'b0;
    bus.h_ready = 1'b0;
    pcm_mb("t5a", 6, 24, 24, 1'b0);
    cfg_force_pcm = 1'b0;
    decide("t5b eq", 16'd3200, 1'b1);
    pcm_mb("t5b", 7, 24, 24, 1'b0);
    decide("t5c below", 16'd3199, 1'b0);
    drain_mb("t5c", 8, 24, 24);
    idle_check("t5c");
    $display("txn: t5 force/threshold boundary");

    // 6: asynchronous reset mid-MB
    decide("t6 dec", 16'd4000, 1'b1);
    for (int b = 1; b <= 9; b++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = word(9, b);
      bus.s_last  = 1'b0;
      step();
    end
    bus.s_data = word(9, 10);
    #2;
    reset = 1'b1;
    #1;
    chk("t6 rst m_valid", bus.m_valid, 1'b0);
    chk("t6 rst m_data",  bus.m_data,  128'd0);
    chk("t6 rst m_last",  bus.m_last,  1'b0);
    chk("t6 rst s_ready", bus.s_ready, 1'b0);
    chk("t6 rst h_valid", bus.h_valid, 1'b0);
    chk("t6 rst err_len", err_len, 1'b0);
    chk("t6 rst stat_tot", stat_tot_mbs, 16'd0);
    bus.s_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    $display("txn: t6 reset mid-MB");

    for (int k = 0; k < 3; k++) begin
      decide("t6 pcm dec", 16'd4000, 1'b1);
      pcm_mb("t6 pcm", 10 + k, 24, 24, 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      decide("t6 cod dec", 16'd100, 1'b0);
      drain_mb("t6 cod", 20 + k, 24, 24);
    end
    idle_check("t6 post");
    chk("t6 post err_len", err_len, 1'b0);
`ifdef GG_PCM_STATS_EN
    chk("t6 stat_pcm", stat_pcm_mbs, 16'd3);
    chk("t6 stat_tot", stat_tot_mbs, 16'd5);
`else
    chk("t6 stat_pcm", stat_pcm_mbs, 16'd0);
    chk("t6 stat_tot", stat_tot_mbs, 16'd0);
`endif
    $display("txn: t6 3 PCM + 2 coded after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
